// File: rtl/match_pkg.sv
// Shared constants for the match sequencer: state codes,
// field widths and parameter defaults.
package match_pkg;

  localparam int SCORE_W = 5;
  localparam int TIMER_W = 8;

  localparam int WIN_SCORE_DEF    = 11;
  localparam int SERVE_FRAMES_DEF = 120;
  localparam int POINT_FRAMES_DEF = 60;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SERVE = 3'd1;
  localparam logic [2:0] ST_PLAY  = 3'd2;
  localparam logic [2:0] ST_POINT = 3'd3;
  localparam logic [2:0] ST_OVER  = 3'd4;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

endpackage

// File: rtl/match_sequencer_frame_timer.sv
// frame_timer: loadable frame down-counter.
// Ports: clk, rst, load/load_val, tick, freeze -> count, done.
module frame_timer
  import match_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               tick,
  input  logic               freeze,
  output logic [TIMER_W-1:0] count,
  output logic               done
);

  logic [TIMER_W-1:0] count_q;
  logic [TIMER_W-1:0] count_d;
  logic               step;

  // A tick seen while frozen is dropped, never remembered.
  assign step = tick && !freeze && (count_q != '0);

  // done flags the tick that takes the count from 1 to 0.
  assign done  = step && (count_q == TIMER_W'(1));
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (step) begin
      count_d = count_q - TIMER_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/match_sequencer.sv
// match_sequencer: pong-style match FSM (serve, play, point, over).
// In: clk, rst, frame_tick, start, pause, point_p1/p2.
// Out: state, ball_en, ball_reset, serve_dir, score1/2, winner, timer.
module match_sequencer
  import match_pkg::*;
#(
  parameter int WIN_SCORE    = WIN_SCORE_DEF,
  parameter int SERVE_FRAMES = SERVE_FRAMES_DEF,
  parameter int POINT_FRAMES = POINT_FRAMES_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               pause,
  input  logic               point_p1,
  input  logic               point_p2,
  output logic [2:0]         state,
  output logic               ball_en,
  output logic               ball_reset,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic [1:0]         winner,
  output logic [TIMER_W-1:0] timer
);

  localparam logic [SCORE_W-1:0] WIN_L   = SCORE_W'(WIN_SCORE);
  localparam logic [TIMER_W-1:0] SERVE_L = TIMER_W'(SERVE_FRAMES);
  localparam logic [TIMER_W-1:0] POINT_L = TIMER_W'(POINT_FRAMES);

  logic [2:0]         state_q, state_d;
  logic               ball_en_q, ball_en_d;
  logic               ball_reset_q, ball_reset_d;
  logic               serve_dir_q, serve_dir_d;
  logic [SCORE_W-1:0] score1_q, score1_d;
  logic [SCORE_W-1:0] score2_q, score2_d;
  logic [1:0]         winner_q, winner_d;

  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_val;
  logic               tmr_tick;
  logic               tmr_done;
  logic [SCORE_W-1:0] s1_inc, s2_inc;

  // Only the SERVE and POINT waits consume frames.
  assign tmr_tick = frame_tick &&
                    (state_q == ST_SERVE || state_q == ST_POINT);

  assign s1_inc = score1_q + SCORE_W'(1);
  assign s2_inc = score2_q + SCORE_W'(1);

  frame_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tick     (tmr_tick),
    .freeze   (pause),
    .count    (timer),
    .done     (tmr_done)
  );

  always_comb begin
    state_d     = state_q;
    serve_dir_d = serve_dir_q;
    score1_d    = score1_q;
    score2_d    = score2_q;
    winner_d    = winner_q;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          score1_d = '0;
          score2_d = '0;
          winner_d = WIN_NONE;
          tmr_load = 1'b1;
          tmr_val  = SERVE_L;
          state_d  = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (tmr_done) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (point_p1 && point_p2) begin
          // A let replays the serve without scoring.
          tmr_load = 1'b1;
          tmr_val  = SERVE_L;
          state_d  = ST_SERVE;
        end else if (point_p1 && score1_q < WIN_L) begin
          score1_d    = s1_inc;
          serve_dir_d = 1'b1;
          tmr_load    = 1'b1;
          if (s1_inc == WIN_L) begin
            winner_d = WIN_P1;
            tmr_val  = '0;
            state_d  = ST_OVER;
          end else begin
            tmr_val  = POINT_L;
            state_d  = ST_POINT;
          end
        end else if (point_p2 && score2_q < WIN_L) begin
          score2_d    = s2_inc;
          serve_dir_d = 1'b0;
          tmr_load    = 1'b1;
          if (s2_inc == WIN_L) begin
            winner_d = WIN_P2;
            tmr_val  = '0;
            state_d  = ST_OVER;
          end else begin
            tmr_val  = POINT_L;
            state_d  = ST_POINT;
          end
        end
      end
      ST_POINT: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = SERVE_L;
          state_d  = ST_SERVE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Ball controls are registered from the next state so they line
  // up with the state they belong to.
  always_comb begin
    ball_en_d    = (state_d == ST_PLAY) && !pause;
    ball_reset_d = !(state_d == ST_PLAY || state_d == ST_POINT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ball_en_q    <= 1'b0;
      ball_reset_q <= 1'b1;
      serve_dir_q  <= 1'b0;
      score1_q     <= '0;
      score2_q     <= '0;
      winner_q     <= WIN_NONE;
    end else begin
      state_q      <= state_d;
      ball_en_q    <= ball_en_d;
      ball_reset_q <= ball_reset_d;
      serve_dir_q  <= serve_dir_d;
      score1_q     <= score1_d;
      score2_q     <= score2_d;
      winner_q     <= winner_d;
    end
  end

  assign state      = state_q;
  assign ball_en    = ball_en_q;
  assign ball_reset = ball_reset_q;
  assign serve_dir  = serve_dir_q;
  assign score1     = score1_q;
  assign score2     = score2_q;
  assign winner     = winner_q;

endmodule

// File: tb/tb_match_sequencer.sv
// Directed bench for match_sequencer with SERVE_FRAMES=3,
// POINT_FRAMES=60, WIN_SCORE=11.
module tb_match_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       point_p1 = 1'b0;
  logic       point_p2 = 1'b0;
  logic [2:0] state;
  logic       ball_en;
  logic       ball_reset;
  logic       serve_dir;
  logic [4:0] score1;
  logic [4:0] score2;
  logic [1:0] winner;
  logic [7:0] timer;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  match_sequencer #(
    .WIN_SCORE    (11),
    .SERVE_FRAMES (3),
    .POINT_FRAMES (60)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .start      (start),
    .pause      (pause),
    .point_p1   (point_p1),
    .point_p2   (point_p2),
    .state      (state),
    .ball_en    (ball_en),
    .ball_reset (ball_reset),
    .serve_dir  (serve_dir),
    .score1     (score1),
    .score2     (score2),
    .winner     (winner),
    .timer      (timer)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_pts(input logic a, input logic b);
    point_p1 = a;
    point_p2 = b;
    step();
    point_p1 = 1'b0;
    point_p2 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    checks++;
    if (state !== 3'd0 || timer !== 8'd0 || winner !== 2'b00) begin
      errors++;
      $display("FAIL reset_state st=%0d tmr=%0d win=%0d exp 0 0 0",
               state, timer, winner);
    end
    checks++;
    if (score1 !== 5'd0 || score2 !== 5'd0) begin
      errors++;
      $display("FAIL reset_score %0d %0d exp 0 0", score1, score2);
    end
    checks++;
    if (ball_en !== 1'b0 || ball_reset !== 1'b1 ||
        serve_dir !== 1'b0) begin
      errors++;
      $display("FAIL reset_ball en=%b rs=%b dir=%b exp 0 1 0",
               ball_en, ball_reset, serve_dir);
    end
  endtask

  task automatic test_serve();
    pulse_start();
    checks++;
    if (state !== 3'd1 || timer !== 8'd3 || ball_reset !== 1'b1) begin
      errors++;
      $display("FAIL serve_enter st=%0d tmr=%0d rs=%b exp 1 3 1",
               state, timer, ball_reset);
    end
    step();
    frame();
    step();
    frame();
    checks++;
    if (state !== 3'd1 || timer !== 8'd1 || ball_en !== 1'b0) begin
      errors++;
      $display("FAIL serve_count st=%0d tmr=%0d en=%b exp 1 1 0",
               state, timer, ball_en);
    end
    frame();
    checks++;
    if (state !== 3'd2 || timer !== 8'd0 || ball_en !== 1'b1 ||
        ball_reset !== 1'b0) begin
      errors++;
      $display("FAIL serve_play st=%0d tmr=%0d en=%b rs=%b exp 2 0 1 0",
               state, timer, ball_en, ball_reset);
    end
  endtask

  task automatic test_point_p2();
    pulse_pts(1'b0, 1'b1);
    checks++;
    if (state !== 3'd3 || score2 !== 5'd1 || serve_dir !== 1'b0 ||
        timer !== 8'd60) begin
      errors++;
      $display("FAIL p2_point st=%0d s2=%0d dir=%b tmr=%0d exp 3 1 0 60",
               state, score2, serve_dir, timer);
    end
    pulse_pts(1'b1, 1'b0);
    checks++;
    if (score1 !== 5'd0 || state !== 3'd3) begin
      errors++;
      $display("FAIL p2_ignore s1=%0d st=%0d exp 0 3", score1, state);
    end
    for (int i = 0; i < 59; i++) frame();
    checks++;
    if (state !== 3'd3 || timer !== 8'd1) begin
      errors++;
      $display("FAIL p2_wait st=%0d tmr=%0d exp 3 1", state, timer);
    end
    frame();
    checks++;
    if (state !== 3'd1 || timer !== 8'd3 || ball_reset !== 1'b1) begin
      errors++;
      $display("FAIL p2_reserve st=%0d tmr=%0d rs=%b exp 1 3 1",
               state, timer, ball_reset);
    end
    for (int i = 0; i < 3; i++) frame();
  endtask

  task automatic test_let();
    pulse_pts(1'b1, 1'b1);
    checks++;
    if (state !== 3'd1 || score1 !== 5'd0 || score2 !== 5'd1 ||
        serve_dir !== 1'b0 || timer !== 8'd3) begin
      errors++;
      $display("FAIL let st=%0d s1=%0d s2=%0d dir=%b tmr=%0d exp 1 0 1 0 3",
               state, score1, score2, serve_dir, timer);
    end
  endtask

  task automatic test_pause();
    pause = 1'b1;
    for (int i = 0; i < 5; i++) frame();
    checks++;
    if (state !== 3'd1 || timer !== 8'd3 || ball_en !== 1'b0) begin
      errors++;
      $display("FAIL pause_serve st=%0d tmr=%0d en=%b exp 1 3 0",
               state, timer, ball_en);
    end
    pause = 1'b0;
    step();
    checks++;
    if (timer !== 8'd3) begin
      errors++;
      $display("FAIL pause_noqueue tmr=%0d exp 3", timer);
    end
    for (int i = 0; i < 3; i++) frame();
    checks++;
    if (state !== 3'd2 || ball_en !== 1'b1) begin
      errors++;
      $display("FAIL pause_resume st=%0d en=%b exp 2 1", state, ball_en);
    end
    pause = 1'b1;
    step();
    step();
    checks++;
    if (state !== 3'd2 || ball_en !== 1'b0) begin
      errors++;
      $display("FAIL pause_play st=%0d en=%b exp 2 0", state, ball_en);
    end
    pause = 1'b0;
    step();
    checks++;
    if (ball_en !== 1'b1) begin
      errors++;
      $display("FAIL unpause_play en=%b exp 1", ball_en);
    end
  endtask

  task automatic test_win();
    for (int i = 0; i < 10; i++) begin
      pulse_pts(1'b1, 1'b0);
      for (int j = 0; j < 63; j++) frame();
    end
    checks++;
    if (score1 !== 5'd10 || state !== 3'd2 || serve_dir !== 1'b1) begin
      errors++;
      $display("FAIL win_pre s1=%0d st=%0d dir=%b exp 10 2 1",
               score1, state, serve_dir);
    end
    pulse_pts(1'b1, 1'b0);
    checks++;
    if (score1 !== 5'd11 || winner !== 2'b01 || state !== 3'd4 ||
        timer !== 8'd0) begin
      errors++;
      $display("FAIL win_over s1=%0d win=%0d st=%0d tmr=%0d exp 11 1 4 0",
               score1, winner, state, timer);
    end
    checks++;
    if (ball_en !== 1'b0 || ball_reset !== 1'b1) begin
      errors++;
      $display("FAIL win_ball en=%b rs=%b exp 0 1", ball_en, ball_reset);
    end
    pulse_pts(1'b1, 1'b0);
    frame();
    checks++;
    if (score1 !== 5'd11 || state !== 3'd4) begin
      errors++;
      $display("FAIL win_hold s1=%0d st=%0d exp 11 4", score1, state);
    end
    pulse_start();
    checks++;
    if (score1 !== 5'd0 || score2 !== 5'd0 || winner !== 2'b00 ||
        state !== 3'd1 || timer !== 8'd3) begin
      errors++;
      $display("FAIL restart s1=%0d s2=%0d win=%0d st=%0d tmr=%0d exp 0 0 0 1 3",
               score1, score2, winner, state, timer);
    end
    frame();
    pulse_start();
    checks++;
    if (state !== 3'd1 || timer !== 8'd2) begin
      errors++;
      $display("FAIL start_ignored st=%0d tmr=%0d exp 1 2", state, timer);
    end
  endtask

  task automatic test_async_reset();
    frame();
    frame();
    pulse_pts(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) frame();
    checks++;
    if (state !== 3'd3 || timer !== 8'd56 || score2 !== 5'd1) begin
      errors++;
      $display("FAIL pre_rst st=%0d tmr=%0d s2=%0d exp 3 56 1",
               state, timer, score2);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (state !== 3'd0 || timer !== 8'd0 || score2 !== 5'd0 ||
        winner !== 2'b00 || ball_en !== 1'b0 || ball_reset !== 1'b1 ||
        serve_dir !== 1'b0) begin
      errors++;
      $display("FAIL async_rst st=%0d tmr=%0d s2=%0d win=%0d en=%b rs=%b dir=%b",
               state, timer, score2, winner, ball_en, ball_reset, serve_dir);
    end
    step();
    rst = 1'b0;
    step();
    checks++;
    if (state !== 3'd0 || score1 !== 5'd0) begin
      errors++;
      $display("FAIL post_rst st=%0d s1=%0d exp 0 0", state, score1);
    end
  endtask

  initial begin
    test_reset();
    test_serve();
    test_point_p2();
    test_let();
    test_pause();
    test_win();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
